// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Shares the single L2 cache port between the L1 I-cache (read-only) and the
// L1 D-cache (read/write). One requester is granted for a whole transaction.
// Its strobes, address and write data pass straight through to L2. The L2
// read line is broadcast to both L1 read-data ports.
//
// Arbitration uses the FSM states IDLE, SERVE_I and SERVE_D. A decision made
// in IDLE takes effect on the next clock edge. When both requesters ask at
// once, the master that was not granted last time wins if RR_EN is set.
// Otherwise the D-cache wins. After every transaction the FSM spends at least
// one cycle in IDLE, which gives the finished requester time to drop its
// strobe.
//
// A saturating counter records how many cycles one requester waited while the
// other one held the port. It is intended for performance monitoring.
//
// Ports:
//   clk             clock; all state updates on the rising edge
//   reset           asynchronous, active-high reset
//   icache_read     I-cache line-read request, held until icache_resp
//   icache_address  I-cache line address
//   icache_rdata    line data to the I-cache (copy of l2_rdata)
//   icache_resp     one-cycle completion pulse to the I-cache
//   dcache_read     D-cache line-read request, held until dcache_resp
//   dcache_write    D-cache writeback request, held until dcache_resp
//   dcache_address  D-cache line address
//   dcache_wdata    D-cache writeback data
//   dcache_rdata    line data to the D-cache (copy of l2_rdata)
//   dcache_resp     one-cycle completion pulse to the D-cache
//   l2_read         read strobe to L2
//   l2_write        write strobe to L2
//   l2_address      address to L2
//   l2_wdata        write data to L2
//   l2_rdata        read data from L2
//   l2_resp         completion pulse from L2
//   grant           01 = I served, 10 = D served, 00 = idle
//   conflict_count  saturating count of cycles spent waiting on the other master
// ---------------------------------------------------------------------------
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,

  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,

  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,

  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_next;

  // Records which master was granted most recently: 1 = D-cache, 0 = I-cache.
  logic last_grant_d;
  logic last_grant_d_next;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic conflict_inc;

  // The D-cache counts as requesting when either of its strobes is high.
  // If both strobes are high, that is a protocol violation. Both strobes are
  // still forwarded to L2 unchanged.
  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  // Tie-break rule. With round-robin enabled, the master not served last time
  // wins. With round-robin disabled, the D-cache always wins.
  assign pick_d = (RR_EN == 1'b0) || !last_grant_d;

  // The read line goes to both L1s. Each L1 uses it only when its own
  // response pulse is high.
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

  // State register. Reset is asynchronous, so grant and the L2 strobes drop at
  // once and any transfer in flight is abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant_d <= last_grant_d_next;
    end
  end

  // Next-state and output logic.
  // In IDLE, all strobes stay low and any l2_resp is ignored. A stale pulse
  // after reset is one example of such a pulse.
  // In a SERVE state, the granted master's signals pass straight through.
  // l2_resp becomes that master's response pulse in the same cycle.
  // Dropping every strobe without a response aborts the transaction.
  always_comb begin
    state_next        = state;
    last_grant_d_next = last_grant_d;
    l2_read           = 1'b0;
    l2_write          = 1'b0;
    l2_address        = '0;
    l2_wdata          = '0;
    icache_resp       = 1'b0;
    dcache_resp       = 1'b0;
    grant             = 2'b00;

    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (pick_d) begin
            state_next        = SERVE_D;
            last_grant_d_next = 1'b1;
          end else begin
            state_next        = SERVE_I;
            last_grant_d_next = 1'b0;
          end
        end else if (d_req) begin
          state_next        = SERVE_D;
          last_grant_d_next = 1'b1;
        end else if (i_req) begin
          state_next        = SERVE_I;
          last_grant_d_next = 1'b0;
        end
      end

      SERVE_I: begin
        grant       = 2'b01;
        l2_read     = icache_read;
        l2_address  = icache_address;
        icache_resp = l2_resp;
        if (l2_resp || !i_req) begin
          state_next = IDLE;
        end
      end

      SERVE_D: begin
        grant       = 2'b10;
        l2_read     = dcache_read;
        l2_write    = dcache_write;
        l2_address  = dcache_address;
        l2_wdata    = dcache_wdata;
        dcache_resp = l2_resp;
        if (l2_resp || !d_req) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A conflict cycle is any cycle in which one master holds the port while
  // the other master is requesting. IDLE cycles never count.
  assign conflict_inc = ((state == SERVE_I) && d_req) ||
                        ((state == SERVE_D) && i_req);

  // The conflict counter stops at all-ones rather than wrapping, so a
  // saturated value still reads as "at least this many".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (conflict_inc && (conflict_count != CNT_MAX)) begin
      conflict_count <= conflict_count + CNT_ONE;
    end
  end

endmodule
